// File: rtl/ecg_beat_detector.sv
// ECG front-end: 4-tap moving-average filter feeding a hysteresis R-peak detector
// with a refractory window, R-R interval measurement and asystole flag.
module ecg_beat_detector #(
    parameter logic [9:0] THRESH_HI  = 10'd600,
    parameter logic [9:0] THRESH_LO  = 10'd500,
    parameter logic [7:0] REFRACTORY = 8'd50,
    parameter logic [7:0] RR_MAX     = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] adc_in,
    input  logic       adc_valid,
    output logic [9:0] filt_out,
    output logic       filt_valid,
    output logic       beat_pulse,
    output logic [7:0] rr_interval,
    output logic       rr_valid,
    output logic       asystole,
    output logic [1:0] det_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PEAK    = 2'd2,
        REFRACT = 2'd3
    } state_t;

    logic [9:0]  window_reg [4];
    logic [11:0] sum_reg;
    logic [11:0] sum_next;
    logic [2:0]  fill_reg;

    state_t      state_reg;
    logic [7:0]  refr_reg;
    logic [7:0]  cnt_reg;
    logic        have_prev_reg;
    logic        beat;
    logic [8:0]  cnt_inc;
    logic [7:0]  n_next;

    // Oldest sample leaves as the new one enters; empty slots hold zero during fill.
    assign sum_next = sum_reg + {2'b00, adc_in} - {2'b00, window_reg[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) window_reg[i] <= '0;
            sum_reg    <= '0;
            fill_reg   <= '0;
            filt_out   <= '0;
            filt_valid <= 1'b0;
        end else if (!enable) begin
            for (int i = 0; i < 4; i++) window_reg[i] <= '0;
            sum_reg    <= '0;
            fill_reg   <= '0;
            filt_out   <= '0;
            filt_valid <= 1'b0;
        end else begin
            filt_valid <= 1'b0;
            if (adc_valid) begin
                window_reg[0] <= adc_in;
                for (int i = 1; i < 4; i++) window_reg[i] <= window_reg[i-1];
                sum_reg <= sum_next;
                if (fill_reg != 3'd4) fill_reg <= fill_reg + 3'd1;
                if (fill_reg >= 3'd3) begin
                    filt_valid <= 1'b1;
                    filt_out   <= sum_next[11:2];
                end
            end
        end
    end

    assign beat      = (state_reg == ARMED) && (filt_out > THRESH_HI);
    assign cnt_inc   = {1'b0, cnt_reg} + 9'd1;
    assign n_next    = (cnt_inc >= {1'b0, RR_MAX}) ? RR_MAX : cnt_inc[7:0];
    assign det_state = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            refr_reg      <= '0;
            cnt_reg       <= '0;
            have_prev_reg <= 1'b0;
            beat_pulse    <= 1'b0;
            rr_interval   <= '0;
            rr_valid      <= 1'b0;
            asystole      <= 1'b0;
        end else if (!enable) begin
            // rr_interval deliberately keeps the last measured value
            state_reg     <= IDLE;
            refr_reg      <= '0;
            cnt_reg       <= '0;
            have_prev_reg <= 1'b0;
            beat_pulse    <= 1'b0;
            rr_valid      <= 1'b0;
            asystole      <= 1'b0;
        end else begin
            beat_pulse <= 1'b0;
            rr_valid   <= 1'b0;
            if (state_reg == IDLE) state_reg <= ARMED;
            if (filt_valid) begin
                case (state_reg)
                    ARMED:   if (beat) state_reg <= PEAK;
                    PEAK: begin
                        if (filt_out < THRESH_LO) begin
                            state_reg <= REFRACT;
                            refr_reg  <= REFRACTORY;
                        end
                    end
                    REFRACT: begin
                        // a count of 1 or 0 means this sample finishes the window
                        if (refr_reg <= 8'd1) begin
                            state_reg <= ARMED;
                            refr_reg  <= '0;
                        end else begin
                            refr_reg <= refr_reg - 8'd1;
                        end
                    end
                    default: ;
                endcase
                if (beat) begin
                    cnt_reg <= '0;
                    if (have_prev_reg && (n_next < RR_MAX)) begin
                        rr_interval <= n_next;
                        rr_valid    <= 1'b1;
                    end
                    have_prev_reg <= 1'b1;
                    beat_pulse    <= 1'b1;
                    asystole      <= 1'b0;
                end else begin
                    cnt_reg <= n_next;
                    if ((n_next == RR_MAX) && have_prev_reg) asystole <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecg_beat_detector.sv
// Randomized bench for ecg_beat_detector: every cycle is compared against a
// sample-level reference model (queue-based filter, index-based R-R tracking).
module tb_ecg_beat_detector;
    localparam int HI   = 600;
    localparam int LO   = 500;
    localparam int REFR = 10;
    localparam int RRM  = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [9:0] adc_in = '0;
    logic       adc_valid = 1'b0;
    logic [9:0] filt_out;
    logic       filt_valid;
    logic       beat_pulse;
    logic [7:0] rr_interval;
    logic       rr_valid;
    logic       asystole;
    logic [1:0] det_state;

    ecg_beat_detector #(
        .THRESH_HI(10'd600), .THRESH_LO(10'd500), .REFRACTORY(8'd10), .RR_MAX(8'd255)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .adc_in(adc_in), .adc_valid(adc_valid),
        .filt_out(filt_out), .filt_valid(filt_valid), .beat_pulse(beat_pulse),
        .rr_interval(rr_interval), .rr_valid(rr_valid), .asystole(asystole),
        .det_state(det_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       v;
        logic [9:0] d;
    } stim_t;

    stim_t stim[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    beats, rrs, mark;
    logic [7:0] last_rr;
    bit    asys_seen;

    // ---------------- reference model ----------------
    int         q[$];
    logic       m_fv;
    logic [9:0] m_fo;
    logic       m_beat, m_rrv, m_asys;
    logic [7:0] m_rr;
    logic [1:0] m_mode;   // 0 idle, 1 armed, 2 peak, 3 refractory
    int         refr_left, since;
    bit         have_prev;

    function automatic void model_reset();
        q.delete();
        m_fv = 0; m_fo = 0; m_beat = 0; m_rrv = 0; m_asys = 0; m_rr = 0;
        m_mode = 0; refr_left = 0; since = 0; have_prev = 0;
    endfunction

    function automatic void model_edge(input stim_t s);
        int  sum;
        bit  is_beat;
        if (s.rst) begin
            model_reset();
            return;
        end
        m_beat = 0;
        m_rrv  = 0;
        if (!s.en) begin
            m_mode = 0; refr_left = 0; since = 0; have_prev = 0; m_asys = 0;
        end else begin
            if (m_fv) begin
                is_beat = (m_mode == 1) && (int'(m_fo) > HI);
                since++;
                if (is_beat) begin
                    if (have_prev && since < RRM) begin
                        m_rr  = 8'(since);
                        m_rrv = 1;
                    end
                    have_prev = 1;
                    since     = 0;
                    m_asys    = 0;
                    m_mode    = 2;
                end else begin
                    if (have_prev && since >= RRM) m_asys = 1;
                    if (m_mode == 2 && int'(m_fo) < LO) begin
                        m_mode    = 3;
                        refr_left = REFR;
                    end else if (m_mode == 3) begin
                        refr_left--;
                        if (refr_left <= 0) m_mode = 1;
                    end
                end
                m_beat = is_beat;
            end
            if (m_mode == 0) m_mode = 1;
        end
        if (!s.en) begin
            q.delete(); m_fv = 0; m_fo = 0;
        end else if (s.v) begin
            q.push_back(int'(s.d));
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) begin
                sum = 0;
                foreach (q[k]) sum += q[k];
                m_fv = 1;
                m_fo = 10'(sum / 4);
            end else begin
                m_fv = 0;
            end
        end else begin
            m_fv = 0;
        end
    endfunction

    function automatic logic [23:0] dut_vec();
        return {filt_valid, filt_out, beat_pulse, rr_valid, rr_interval, asystole, det_state};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {m_fv, m_fo, m_beat, m_rrv, m_rr, m_asys, m_mode};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic add_idle(input logic en, input int count);
        stim_t s;
        for (int k = 0; k < count; k++) begin
            s.rst = 0; s.en = en; s.v = 1'($urandom_range(0, 1)); s.d = 10'($urandom_range(0, 1023));
            if (en) s.v = 0;
            stim.push_back(s);
        end
    endtask

    task automatic add_run(input int val, input int count, input int noise, input bit gaps);
        stim_t s;
        int    g;
        for (int k = 0; k < count; k++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            add_idle(1'b1, g);
            s.rst = 0; s.en = 1; s.v = 1;
            s.d = 10'(val + int'($urandom_range(0, 2 * noise)) - noise);
            stim.push_back(s);
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        reset = s.rst; enable = s.en; adc_valid = s.v; adc_in = s.d;
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    task automatic tally();
        if (beat_pulse) beats++;
        if (rr_valid) begin
            rrs++;
            last_rr = rr_interval;
        end
        if (asystole) asys_seen = 1;
    endtask

    task automatic clear_tally();
        beats = 0; rrs = 0; last_rr = 0; asys_seen = 0;
        stim.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t s;
        clear_tally();
        for (int k = 0; k < 3; k++) begin
            s.rst = 1; s.en = 1'($urandom_range(0, 1)); s.v = 1'($urandom_range(0, 1));
            s.d = 10'($urandom_range(0, 1023));
            stim.push_back(s);
        end
        add_idle(1'b1, 1);
        add_run(700, 4, 0, 0);
        add_idle(1'b1, 2);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            if (i < 3) begin
                vectors++;
                if (dut_vec() !== 24'h0) begin
                    miscompares++;
                    $display("FAIL reset_zero[%0d] dut=%h expected=000000", i, dut_vec());
                end
            end
            if (i == 7) begin
                vectors++;
                if ({filt_valid, filt_out} !== {1'b1, 10'd700}) begin
                    miscompares++;
                    $display("FAIL first_filt got valid=%b out=%0d expected valid=1 out=700", filt_valid, filt_out);
                end
            end
            if (i == 8) begin
                vectors++;
                if ({beat_pulse, rr_valid, det_state} !== {1'b1, 1'b0, 2'd2}) begin
                    miscompares++;
                    $display("FAIL first_beat got beat=%b rrv=%b state=%0d expected 1 0 2", beat_pulse, rr_valid, det_state);
                end
            end
        end
    endtask

    task automatic test_periodic();
        clear_tally();
        add_idle(1'b0, 2);
        add_run(200, 8, 10, 1);
        for (int p = 0; p < 4; p++) begin
            add_run(800, 5, 10, 1);
            add_run(200, 55, 10, 1);
        end
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL periodic[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
            if (rr_valid && rr_interval !== 8'd60) begin
                miscompares++;
                $display("FAIL periodic_rr got %0d expected 60", rr_interval);
            end
        end
        vectors++;
        if (beats != 4 || rrs != 3 || last_rr !== 8'd60) begin
            miscompares++;
            $display("FAIL periodic_count got beats=%0d rr=%0d last=%0d expected 4 3 60", beats, rrs, last_rr);
        end
    endtask

    task automatic test_hysteresis();
        clear_tally();
        add_idle(1'b0, 2);
        add_run(200, 8, 10, 1);
        add_run(800, 6, 10, 1);
        for (int k = 0; k < 8; k++) add_run((k % 2) ? 550 : 650, int'($urandom_range(4, 6)), 10, 1);
        add_run(300, 20, 10, 1);
        mark = stim.size() - 1;
        add_run(700, 8, 10, 1);
        add_run(300, 8, 10, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL hysteresis[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
            if (i == mark) begin
                vectors++;
                if (beats != 1) begin
                    miscompares++;
                    $display("FAIL hysteresis_band got beats=%0d expected 1", beats);
                end
            end
        end
        vectors++;
        if (beats != 2) begin
            miscompares++;
            $display("FAIL hysteresis_count got beats=%0d expected 2", beats);
        end
    endtask

    task automatic test_refractory();
        clear_tally();
        add_idle(1'b0, 2);
        add_run(200, 8, 0, 1);
        add_run(800, 4, 0, 1);
        add_run(200, 5, 0, 1);
        add_run(800, 4, 0, 1);
        add_run(200, 20, 0, 1);
        mark = stim.size() - 1;
        add_idle(1'b0, 2);
        add_run(200, 8, 0, 1);
        add_run(800, 4, 0, 1);
        add_run(200, 12, 0, 1);
        add_run(800, 4, 0, 1);
        add_run(200, 10, 0, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL refractory[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
            if (i == mark) begin
                vectors++;
                if (beats != 1) begin
                    miscompares++;
                    $display("FAIL refractory_reject got beats=%0d expected 1", beats);
                end
                beats = 0;
            end
        end
        vectors++;
        if (beats != 2) begin
            miscompares++;
            $display("FAIL refractory_accept got beats=%0d expected 2", beats);
        end
    endtask

    task automatic test_asystole_back_to_back();
        clear_tally();
        add_idle(1'b0, 2);
        add_run(200, 8, 10, 0);
        add_run(800, 5, 10, 0);
        add_run(200, 300, 10, 0);
        mark = stim.size() - 1;
        add_run(800, 5, 10, 0);
        add_run(200, 55, 10, 0);
        add_run(800, 5, 10, 0);
        add_run(200, 10, 10, 0);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL asystole[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
            if (i == mark) begin
                vectors++;
                if (asystole !== 1'b1 || rrs != 0) begin
                    miscompares++;
                    $display("FAIL asystole_rise got asys=%b rr=%0d expected 1 0", asystole, rrs);
                end
            end
        end
        vectors++;
        if (beats != 3 || rrs != 1 || last_rr !== 8'd60 || asystole !== 1'b0 || !asys_seen) begin
            miscompares++;
            $display("FAIL asystole_end got beats=%0d rr=%0d last=%0d asys=%b expected 3 1 60 0", beats, rrs, last_rr, asystole);
        end
    endtask

    task automatic test_abort();
        stim_t s;
        clear_tally();
        add_idle(1'b0, 2);
        add_run(200, 8, 10, 1);
        add_run(800, 4, 10, 1);
        add_idle(1'b1, 2);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_pre[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (det_state !== 2'd2) begin
            miscompares++;
            $display("FAIL abort_in_peak got state=%0d expected 2", det_state);
        end
        #2 reset = 1'b1;
        #1 model_reset();
        vectors++;
        if (dut_vec() !== 24'h0) begin
            miscompares++;
            $display("FAIL abort_async got %h expected 000000", dut_vec());
        end
        clear_tally();
        s.rst = 1; s.en = 1; s.v = 1; s.d = 10'd800;
        stim.push_back(s);
        stim.push_back(s);
        add_idle(1'b1, 1);
        add_run(200, 8, 10, 1);
        add_run(800, 5, 10, 1);
        add_run(200, 55, 10, 1);
        add_run(800, 5, 10, 1);
        add_run(200, 10, 10, 1);
        add_idle(1'b1, 2);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_restart[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
        end
        vectors++;
        if (beats != 2 || rrs != 1 || last_rr !== 8'd60 || det_state !== 2'd3) begin
            miscompares++;
            $display("FAIL abort_restart_sum got beats=%0d rr=%0d last=%0d state=%0d expected 2 1 60 3", beats, rrs, last_rr, det_state);
        end
        s.rst = 0; s.en = 0; s.v = 1; s.d = 10'd800;
        step(s);
        vectors++;
        if (dut_vec() !== {1'b0, 10'd0, 1'b0, 1'b0, 8'd60, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL abort_enable got %h expected %h", dut_vec(), {1'b0, 10'd0, 1'b0, 1'b0, 8'd60, 1'b0, 2'd0});
        end
        clear_tally();
        add_run(200, 8, 10, 1);
        add_run(800, 5, 10, 1);
        add_run(200, 20, 10, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_reenable[%0d] dut=%h expected=%h", i, dut_vec(), exp_vec());
            end
            tally();
        end
        vectors++;
        if (beats != 1 || rrs != 0 || rr_interval !== 8'd60) begin
            miscompares++;
            $display("FAIL abort_first_beat got beats=%0d rr=%0d hold=%0d expected 1 0 60", beats, rrs, rr_interval);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_hysteresis();
        test_refractory();
        test_asystole_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ecg_beat_detector.md
# ecg_beat_detector

Upstream front-end for the heartbeat monitor: conditions raw 10-bit ECG ADC samples with a 4-tap moving average and detects R-peaks using hysteresis thresholds and a refractory window. Each accepted beat produces a one-cycle pulse and, from the second beat onward, the R-R interval in samples. The heart-rate converter consumes the filtered sample stream, beat pulses, R-R intervals and the asystole flag during its measuring window.

## Interface
- THRESH_HI, 10'd600: filtered level that arms a beat (rising crossing, strict >)
- THRESH_LO, 10'd500: filtered level that ends a peak (strict <); must be < THRESH_HI
- REFRACTORY, 8'd50: samples ignored after a peak ends
- RR_MAX, 8'd255: R-R saturation / asystole limit in samples
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  measuring window; low synchronously clears the datapath
- adc_in  in  10  raw ECG sample, qualified by adc_valid
- adc_valid  in  1  one-cycle sample strobe; may be back-to-back
- filt_out  out  10  moving-average sample
- filt_valid  out  1  one-cycle strobe, filt_out valid
- beat_pulse  out  1  one-cycle pulse per accepted R-peak
- rr_interval  out  8  samples between the last two beats
- rr_valid  out  1  one-cycle strobe, rr_interval updated
- asystole  out  1  level; no beat for RR_MAX samples
- det_state  out  2  detector state, for debug

## Operation
- Filter: 4-entry shift window and a 12-bit sum. filt_out = sum[11:2] (truncate, no rounding). A fill counter suppresses filt_valid until the window holds 4 samples since enable rose or reset. The first filt_valid follows the 4th adc_valid.
- Detector FSM, advancing only on filt_valid:
  - IDLE=0: entered when enable is low. Goes to ARMED when enable is high.
  - ARMED=1: if filt_out > THRESH_HI, assert beat_pulse and go to PEAK.
  - PEAK=2: if filt_out < THRESH_LO, go to REFRACT and load the refractory counter with REFRACTORY.
  - REFRACT=3: decrement the counter per filtered sample and go to ARMED on the sample where it reaches 0. No beat is possible in this state. With REFRACTORY=0, go to ARMED on the next filtered sample.
- R-R counter (8-bit), updated on each filt_valid while enable is high:
  - n = min(cnt+1, RR_MAX).
  - Beat sample: cnt<=0. If have_prev=1 and n<RR_MAX, then rr_interval<=n and rr_valid=1. Then have_prev<=1 and asystole<=0.
  - Non-beat sample: cnt<=n. If n==RR_MAX and have_prev=1, then asystole<=1.
  - A saturated interval (n==RR_MAX) never produces rr_valid.
- enable low, applied synchronously, clears the following: window, sum, fill count, cnt, have_prev, asystole, the refractory counter, and the FSM (to IDLE). rr_interval holds its last value. adc_valid is ignored while enable is low.
- Simultaneous events:
  - adc_valid and enable falling in the same cycle: enable wins and the sample is dropped.
  - Beat on the same sample where n hits RR_MAX: treat as a beat, clear asystole, no rr_valid.

## Timing
- Reset (asynchronous) drives every output and internal register to zero: filt_out=0, filt_valid=0, beat_pulse=0, rr_interval=0, rr_valid=0, asystole=0, det_state=IDLE.
- filt_out and filt_valid are registered 1 clk after the adc_valid cycle.
- beat_pulse, rr_valid, rr_interval, asystole and det_state are registered 1 clk after the filt_valid cycle, i.e. 2 clk after the causing adc_valid.
- All strobes are exactly one cycle wide. Back-to-back adc_valid gives back-to-back filt_valid with full throughput and no stalls.
- Reset asserted mid-PEAK or mid-REFRACT aborts immediately. After release, behaviour is identical to a fresh start.

## Test plan
- Reset and fill: assert reset, then release with enable=1 and four samples of 700 -> all outputs 0 during reset; first filt_valid with filt_out=700 1 clk after the 4th adc_valid; beat_pulse 1 clk after that; no rr_valid; det_state=2.
- Periodic beats: square wave, 5 samples at 800 then 55 at 200, for 4 periods, REFRACTORY=10 -> one beat_pulse per period; rr_valid from the 2nd beat with rr_interval=60 each time.
- Hysteresis: after a peak, the filtered level oscillates between 550 and 650 -> no extra beat_pulse until the level drops below 500, then REFRACTORY expires, then it exceeds 600.
- Refractory rejection: a second 800 spike 5 samples after the peak ends, REFRACTORY=10 -> no beat_pulse; a spike at sample 12 -> beat_pulse.
- Asystole: one beat, then a constant 200 -> asystole rises on the filtered sample where n reaches 255, with no rr_valid; the next beat clears asystole without rr_valid, and the following beat yields a valid rr_interval.
- Abort: asynchronous reset mid-PEAK, and separately enable dropped mid-REFRACT -> outputs zeroed (rr_interval holds in the enable case); the FSM restarts from IDLE and the 4-sample fill; the first post-restart beat gives no rr_valid.
